// File: rtl/shadow_ctx_spill_unit_pkg.sv
// shadow_spill_pkg: shared FSM state and frame sizing for the shadow context spill unit.
package shadow_spill_pkg;

    typedef enum logic {IDLE, SPILL} state_t;

    function automatic int frame_bytes(input int xlen, input int nr_regs);
        return nr_regs * xlen / 8;
    endfunction

endpackage

// File: rtl/shadow_ctx_spill_unit_bank.sv
// shadow_ctx_bank: NR_LEVELS x NR_REGS shadow register file, whole-frame write, single word read.
module shadow_ctx_bank #(
    parameter int XLEN      = 64,
    parameter int NR_REGS   = 4,
    parameter int NR_LEVELS = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         we_i,
    input  logic [$clog2(NR_LEVELS)-1:0] wlevel_i,
    input  logic [NR_REGS*XLEN-1:0]      wdata_i,
    input  logic [$clog2(NR_LEVELS)-1:0] rlevel_i,
    input  logic [$clog2(NR_REGS)-1:0]   ridx_i,
    output logic [XLEN-1:0]              rdata_o
);

    logic [XLEN-1:0] mem [NR_LEVELS][NR_REGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int l = 0; l < NR_LEVELS; l++)
                for (int r = 0; r < NR_REGS; r++)
                    mem[l][r] <= '0;
        end else if (we_i) begin
            for (int r = 0; r < NR_REGS; r++)
                mem[wlevel_i][r] <= wdata_i[r*XLEN +: XLEN];
        end
    end

    assign rdata_o = mem[rlevel_i][ridx_i];

endmodule

// File: rtl/shadow_ctx_spill_unit.sv
// shadow_ctx_spill_unit: multi-level interrupt frame capture and stack spill over a req/gnt store port.
// Optional SHADOW_SPILL_PERF_CNT_EN adds completed-frame and grant-wait counters.
module shadow_ctx_spill_unit
    import shadow_spill_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int NR_REGS   = 4,
    parameter int NR_LEVELS = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             save_i,
    input  logic [NR_REGS*XLEN-1:0]          frame_i,
    input  logic [XLEN-1:0]                  sp_i,
    output logic                             save_ready_o,
    output logic [XLEN-1:0]                  next_sp_o,
    input  logic                             restore_i,
    output logic [$clog2(NR_LEVELS+1)-1:0]   level_o,
    output logic                             overflow_o,
    output logic                             st_req_o,
    output logic [XLEN-1:0]                  st_addr_o,
    output logic [XLEN-1:0]                  st_data_o,
    output logic [XLEN/8-1:0]                st_be_o,
    input  logic                             st_gnt_i,
    input  logic [11:0]                      page_offset_i,
    output logic                             offset_match_o,
    input  logic [$clog2(NR_LEVELS)-1:0]     rlevel_i,
    input  logic [$clog2(NR_REGS)-1:0]       ridx_i,
    output logic [XLEN-1:0]                  rdata_o
`ifdef SHADOW_SPILL_PERF_CNT_EN
    ,
    output logic [31:0]                      spill_cnt_o,
    output logic [31:0]                      gnt_wait_cnt_o
`endif
);

    localparam int FB = frame_bytes(XLEN, NR_REGS);
    localparam int WB = XLEN / 8;
    localparam int LW = $clog2(NR_LEVELS);
    localparam int RW = $clog2(NR_REGS);
    localparam int VW = $clog2(NR_LEVELS + 1);

    state_t                  state;
    logic [VW-1:0]           level;
    logic [RW-1:0]           k;
    logic [XLEN-1:0]         base;
    logic [NR_REGS*XLEN-1:0] spill_frame;
    logic                    pend;
    logic                    overflow;
    logic                    save_ok;
    logic                    last_gnt;

    assign save_ready_o = (state == IDLE) && (level < VW'(NR_LEVELS));
    assign save_ok      = save_i && save_ready_o;
    assign last_gnt     = (state == SPILL) && st_gnt_i && (k == '0);

    // A restore during a spill is held and retired on the final grant so the
    // level never drops below a frame that is still being written out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            level       <= '0;
            k           <= '0;
            base        <= '0;
            spill_frame <= '0;
            pend        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (save_i && !save_ready_o)
                overflow <= 1'b1;
            if (state == IDLE) begin
                if (save_ok) begin
                    state       <= SPILL;
                    spill_frame <= frame_i;
                    base        <= sp_i - XLEN'(FB);
                    level       <= level + 1'b1;
                    k           <= RW'(NR_REGS - 1);
                    pend        <= restore_i;
                end else if (restore_i && level != '0) begin
                    level <= level - 1'b1;
                end
            end else begin
                if (restore_i)
                    pend <= 1'b1;
                if (st_gnt_i) begin
                    k <= k - 1'b1;
                    if (k == '0) begin
                        state <= IDLE;
                        pend  <= 1'b0;
                        level <= level - VW'(pend | restore_i);
                    end
                end
            end
        end
    end

    assign level_o    = level;
    assign next_sp_o  = base;
    assign overflow_o = overflow;
    assign st_req_o   = (state == SPILL);
    assign st_addr_o  = base + XLEN'(WB) * XLEN'(k);
    assign st_data_o  = spill_frame[k*XLEN +: XLEN];
    assign st_be_o    = '1;

    always_comb begin
        offset_match_o = 1'b0;
        for (int j = 0; j < NR_REGS; j++)
            offset_match_o = offset_match_o | ((state == SPILL) && (RW'(j) <= k) &&
                             (page_offset_i == 12'(base + XLEN'(j * WB))));
    end

    shadow_ctx_bank #(
        .XLEN      (XLEN),
        .NR_REGS   (NR_REGS),
        .NR_LEVELS (NR_LEVELS)
    ) u_bank (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (save_ok),
        .wlevel_i (level[LW-1:0]),
        .wdata_i  (frame_i),
        .rlevel_i (rlevel_i),
        .ridx_i   (ridx_i),
        .rdata_o  (rdata_o)
    );

`ifdef SHADOW_SPILL_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spill_cnt_o    <= '0;
            gnt_wait_cnt_o <= '0;
        end else begin
            if (last_gnt && spill_cnt_o != '1)
                spill_cnt_o <= spill_cnt_o + 1'b1;
            if (st_req_o && !st_gnt_i && gnt_wait_cnt_o != '1)
                gnt_wait_cnt_o <= gnt_wait_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_shadow_ctx_spill_unit.sv
// tb_shadow_ctx_spill_unit: directed and randomized checks of the spill unit against a queue-based store model.
module tb_shadow_ctx_spill_unit;

    localparam int XLEN      = 64;
    localparam int NR_REGS   = 4;
    localparam int NR_LEVELS = 4;

    logic                  clk = 1'b0;
    logic                  rst_i = 1'b1;
    logic                  save_i = 1'b0;
    logic [NR_REGS*XLEN-1:0] frame_i = '0;
    logic [XLEN-1:0]       sp_i = '0;
    logic                  save_ready_o;
    logic [XLEN-1:0]       next_sp_o;
    logic                  restore_i = 1'b0;
    logic [2:0]            level_o;
    logic                  overflow_o;
    logic                  st_req_o;
    logic [XLEN-1:0]       st_addr_o;
    logic [XLEN-1:0]       st_data_o;
    logic [7:0]            st_be_o;
    logic                  st_gnt_i = 1'b0;
    logic [11:0]           page_offset_i = '0;
    logic                  offset_match_o;
    logic [1:0]            rlevel_i = '0;
    logic [1:0]            ridx_i = '0;
    logic [XLEN-1:0]       rdata_o;
`ifdef SHADOW_SPILL_PERF_CNT_EN
    logic [31:0]           spill_cnt_o;
    logic [31:0]           gnt_wait_cnt_o;
`endif

    always #5 clk = ~clk;

    shadow_ctx_spill_unit #(.XLEN(XLEN), .NR_REGS(NR_REGS), .NR_LEVELS(NR_LEVELS)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .save_i         (save_i),
        .frame_i        (frame_i),
        .sp_i           (sp_i),
        .save_ready_o   (save_ready_o),
        .next_sp_o      (next_sp_o),
        .restore_i      (restore_i),
        .level_o        (level_o),
        .overflow_o     (overflow_o),
        .st_req_o       (st_req_o),
        .st_addr_o      (st_addr_o),
        .st_data_o      (st_data_o),
        .st_be_o        (st_be_o),
        .st_gnt_i       (st_gnt_i),
        .page_offset_i  (page_offset_i),
        .offset_match_o (offset_match_o),
        .rlevel_i       (rlevel_i),
        .ridx_i         (ridx_i),
        .rdata_o        (rdata_o)
`ifdef SHADOW_SPILL_PERF_CNT_EN
        ,
        .spill_cnt_o    (spill_cnt_o),
        .gnt_wait_cnt_o (gnt_wait_cnt_o)
`endif
    );

    typedef struct {logic [63:0] addr; logic [63:0] data;} st_t;

    int          tests = 0;
    int          fails = 0;
    st_t         stq[$];
    int          m_lvl;
    bit          m_ovf;
    bit          m_pend;
    logic [63:0] m_nsp;
    logic [63:0] m_bank [NR_LEVELS][NR_REGS];
    int          m_spills;
    int          m_waits;
    logic [NR_REGS*XLEN-1:0] f;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR_REGS*XLEN-1:0] rand_frame();
        logic [NR_REGS*XLEN-1:0] v;
        for (int i = 0; i < NR_REGS * 2; i++)
            v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        stq.delete();
        m_lvl = 0; m_ovf = 0; m_pend = 0; m_nsp = '0; m_spills = 0; m_waits = 0;
        for (int l = 0; l < NR_LEVELS; l++)
            for (int r = 0; r < NR_REGS; r++)
                m_bank[l][r] = '0;
    endtask

    function automatic bit m_match();
        foreach (stq[i])
            if (stq[i].addr[11:0] == page_offset_i)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_all();
        chk("st_req", st_req_o, stq.size() != 0);
        if (stq.size() != 0) begin
            chk("st_addr", st_addr_o, stq[0].addr);
            chk("st_data", st_data_o, stq[0].data);
        end
        chk("level", level_o, m_lvl);
        chk("save_ready", save_ready_o, stq.size() == 0 && m_lvl < NR_LEVELS);
        chk("overflow", overflow_o, m_ovf);
        chk("next_sp", next_sp_o, m_nsp);
        chk("st_be", st_be_o, 8'hFF);
        chk("offset_match", offset_match_o, m_match());
        chk("rdata", rdata_o, m_bank[rlevel_i][ridx_i]);
`ifdef SHADOW_SPILL_PERF_CNT_EN
        chk("spill_cnt", spill_cnt_o, m_spills);
        chk("gnt_wait_cnt", gnt_wait_cnt_o, m_waits);
`endif
    endtask

    // Advance the reference by one clock using the inputs currently driven.
    task automatic model_update();
        bit          ready;
        logic [63:0] base;
        if (rst_i) begin
            model_reset();
            return;
        end
        ready = stq.size() == 0 && m_lvl < NR_LEVELS;
        if (save_i && !ready)
            m_ovf = 1;
        if (stq.size() != 0) begin
            if (restore_i)
                m_pend = 1;
            if (st_gnt_i) begin
                void'(stq.pop_front());
                if (stq.size() == 0) begin
                    m_spills++;
                    if (m_pend)
                        m_lvl--;
                    m_pend = 0;
                end
            end else begin
                m_waits++;
            end
        end else if (save_i && ready) begin
            base  = sp_i - 64'(NR_REGS * XLEN / 8);
            m_nsp = base;
            for (int r = 0; r < NR_REGS; r++)
                m_bank[m_lvl][r] = frame_i[r*XLEN +: XLEN];
            for (int r = NR_REGS - 1; r >= 0; r--)
                stq.push_back('{base + 64'(r * 8), frame_i[r*XLEN +: XLEN]});
            m_lvl++;
            m_pend = restore_i;
        end else if (restore_i && m_lvl > 0) begin
            m_lvl--;
        end
    endtask

    task automatic step();
        #1;
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        step();

        // single save, grant every cycle
        f = rand_frame(); frame_i = f; sp_i = 64'h8000_1000; save_i = 1'b1; st_gnt_i = 1'b1;
        step();
        save_i = 1'b0;
        chk("t1_next_sp", next_sp_o, 64'h8000_0FE0);
        for (int i = 0; i < NR_REGS; i++) begin
            chk("t1_addr", st_addr_o, 64'h8000_0FF8 - 64'(8 * i));
            chk("t1_data", st_data_o, f[(NR_REGS-1-i)*XLEN +: XLEN]);
            step();
        end
        chk("t1_req_done", st_req_o, 1'b0);
        chk("t1_level", level_o, 3'd1);

        // grant stall on the second store
        f = rand_frame(); frame_i = f; save_i = 1'b1;
        step();
        save_i = 1'b0;
        step();
        st_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_addr_hold", st_addr_o, 64'h8000_0FF0);
            chk("t2_data_hold", st_data_o, f[2*XLEN +: XLEN]);
            step();
        end
        st_gnt_i = 1'b1;
        repeat (3) step();
`ifdef SHADOW_SPILL_PERF_CNT_EN
        chk("t2_gnt_wait", gnt_wait_cnt_o, 32'd3);
`endif

        // load-offset hazard window
        frame_i = rand_frame(); save_i = 1'b1; st_gnt_i = 1'b0;
        step();
        save_i = 1'b0;
        page_offset_i = 12'hFE8;
        #1 chk("t3_match_pending", offset_match_o, 1'b1);
        st_gnt_i = 1'b1;
        repeat (3) step();
        page_offset_i = 12'hFE8;
        #1 chk("t3_match_granted", offset_match_o, 1'b0);
        page_offset_i = 12'hFF8;
        #1 chk("t3_match_first", offset_match_o, 1'b0);
        step();

        // fill to full depth, then overflow
        frame_i = rand_frame(); save_i = 1'b1;
        step();
        save_i = 1'b0;
        repeat (NR_REGS) step();
        chk("t4_level_full", level_o, 3'd4);
        chk("t4_not_ready", save_ready_o, 1'b0);
        save_i = 1'b1;
        step();
        save_i = 1'b0;
        chk("t4_overflow", overflow_o, 1'b1);
        chk("t4_no_req", st_req_o, 1'b0);
        step();

        // restore deferred until the spill completes
        restore_i = 1'b1;
        repeat (3) step();
        restore_i = 1'b0;
        chk("t5_level_down", level_o, 3'd1);
        f = rand_frame(); frame_i = f; sp_i = {$urandom, $urandom}; save_i = 1'b1; st_gnt_i = 1'b0;
        step();
        save_i = 1'b0;
        chk("t5_level_up", level_o, 3'd2);
        restore_i = 1'b1;
        step();
        restore_i = 1'b0;
        chk("t5_level_held", level_o, 3'd2);
        st_gnt_i = 1'b1;
        repeat (3) step();
        chk("t5_level_held_last", level_o, 3'd2);
        step();
        chk("t5_level_popped", level_o, 3'd1);
        rlevel_i = 2'd1; ridx_i = 2'd0;
        #1 chk("t5_rdata_mepc", rdata_o, f[0 +: XLEN]);

        // reset in the middle of a spill
        frame_i = rand_frame(); save_i = 1'b1;
        step();
        save_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("t6_req", st_req_o, 1'b0);
        chk("t6_level", level_o, 3'd0);
        chk("t6_overflow", overflow_o, 1'b0);
        chk("t6_ready", save_ready_o, 1'b1);
        step();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            save_i    = $urandom_range(0, 3) == 0;
            restore_i = !save_i && $urandom_range(0, 3) == 0;
            st_gnt_i  = $urandom_range(0, 2) != 0;
            sp_i      = {$urandom, $urandom};
            frame_i   = rand_frame();
            rlevel_i  = 2'($urandom_range(0, NR_LEVELS - 1));
            ridx_i    = 2'($urandom_range(0, NR_REGS - 1));
            if (stq.size() != 0 && $urandom_range(0, 1) == 0)
                page_offset_i = stq[$urandom_range(0, stq.size() - 1)].addr[11:0];
            else
                page_offset_i = 12'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
